// File: rtl/cpu_ctrl.sv
// Sequencing control for the 4-bit CPU: fetch/decode/execute over a synchronous ROM,
// 4x4 register file, external combinational ALU, and a valid/ready port fed by r3 writes.
module cpu_ctrl #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic            alu_sel,
    input  logic [3:0]      alu_res,
    input  logic            alu_eq,
    output logic [3:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_BEQ  = 2'b11;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [3:0][3:0] regs_q, regs_d;
    logic [3:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;

    logic [1:0]             op;
    logic [1:0]             rd;
    logic [1:0]             rs;
    logic [1:0]             rt;
    logic signed [PC_W-1:0] off_sext;
    logic [PC_W-1:0]        pc_inc;
    logic [PC_W-1:0]        pc_br;
    logic [3:0]             wr_val;

    assign op       = ir_q[7:6];
    assign rd       = ir_q[5:4];
    assign rs       = ir_q[3:2];
    assign rt       = ir_q[1:0];
    assign off_sext = {{(PC_W-2){ir_q[1]}}, ir_q[1:0]};
    assign pc_inc   = pc_q + PC_ONE;
    assign pc_br    = pc_inc + $unsigned(off_sext);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        alu_a       = 4'd0;
        alu_b       = 4'd0;
        alu_sel     = 1'b0;
        wr_val      = 4'd0;

        // A completed transfer clears valid unless a new r3 write below reloads it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op != OP_LDI) begin
                    alu_sel = (op == OP_NAND);
                    alu_a   = (op == OP_BEQ) ? regs_q[rd] : regs_q[rs];
                    alu_b   = (op == OP_BEQ) ? regs_q[rs] : regs_q[rt];
                end
                wr_val = (op == OP_LDI) ? ir_q[3:0] : alu_res;

                if (op == OP_BEQ) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    if (alu_eq) begin
                        pc_d = pc_br;
                        if (ir_q[1:0] == 2'b11) begin
                            state_d = S_HALT;
                        end
                    end
                end else if (rd == 2'd3 && out_valid_q && !out_ready) begin
                    // Output slot still occupied: hold everything and retry next cycle.
                    state_d = S_EXEC;
                end else begin
                    regs_d[rd] = wr_val;
                    if (rd == 2'd3) begin
                        out_data_d  = wr_val;
                        out_valid_d = 1'b1;
                    end
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= 8'd0;
            regs_q      <= '0;
            out_data_q  <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Sequencing control unit for the 4-bit CPU. It fetches 8-bit instructions from a synchronous instruction ROM and holds a 4×4-bit register file. It drives operand and select inputs into the `alu` block (A, B, sel) and consumes its RES/eq outputs for write-back and branching. Results written to r3 are presented on a valid/ready output port.

## Interface
- `PC_W`, default 4: program counter / ROM address width; PC arithmetic wraps mod 2^PC_W.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  PC_W  ROM address; equals PC during FETCH.
- `imem_data`  in  8  ROM data; valid the cycle after `imem_addr` is presented.
- `alu_a`, `alu_b`  out  4  ALU operands.
- `alu_sel`  out  1  ALU select: 0 = add, 1 = nand.
- `alu_res`  in  4  ALU result.
- `alu_eq`  in  1  ALU equality flag (A == B).
- `out_data`  out  4  last value written to r3.
- `out_valid`  out  1  `out_data` pending.
- `out_ready`  in  1  consumer accepts `out_data`.
- `halted`  out  1  CPU stopped.

## Operation
- Instruction fields: [7:6] op, [5:4] rd/ra, [3:2] rs/rb, [1:0] rt/off. LDI uses [3:0] as imm4.
- 00 ADD: rd ← rs + rt via ALU (sel=0), mod 16; overflow is not flagged.
- 01 NAND: rd ← ~(rs & rt) via ALU (sel=1).
- 10 LDI: rd ← imm4. The ALU is not used.
- 11 BEQ: ALU compares ra (A) with rb (B), sel=0.
  - If `alu_eq`: PC ← PC + 1 + sext(off).
  - Otherwise: PC ← PC + 1.
  - A taken BEQ with off = 2'b11 (branch-to-self) enters HALT.
- Any register write with rd = 3 also loads `out_data` and sets `out_valid`.
- FSM states: FETCH → DECODE → EXEC → FETCH, plus HALT.
  - FETCH: present PC on `imem_addr`.
  - DECODE: latch `imem_data` into IR.
  - EXEC: drive the ALU from the register file; at the clock edge, write rd, update PC, and go to FETCH.
  - HALT: terminal; only `rst` exits.
- Non-BEQ instructions advance PC ← PC + 1.

## Timing
- Reset values:
  - PC = 0, r0–r3 = 0, IR = 0, state = FETCH.
  - `imem_addr` = 0, `alu_a` = `alu_b` = 0, `alu_sel` = 0.
  - `out_data` = 0, `out_valid` = 0, `halted` = 0.
- Reset asserted mid-instruction aborts the instruction with no write-back. The first FETCH occurs in the first cycle after `rst` deasserts.
- Normal instruction takes 3 cycles. Register and PC updates are visible at the FETCH of the next instruction.
- `alu_a`/`alu_b`/`alu_sel` carry operands only in EXEC of ADD/NAND/BEQ. At all other times they are 0.
- The ALU is combinational; `alu_res`/`alu_eq` are sampled at the end of EXEC.
- Output handshake:
  - A transfer occurs on a cycle with `out_valid` & `out_ready`.
  - `out_data` is held stable while `out_valid` & !`out_ready`.
- Backpressure stall:
  - An EXEC that writes r3 while `out_valid` & !`out_ready` stays in EXEC. No register, PC or output update occurs, and the ALU operands are held.
  - If `out_ready` is high in that same cycle, the old value transfers and the new value loads. `out_valid` stays 1.
- `out_valid` falls the cycle after the transfer if no new write occurs.
- `halted` rises the cycle after the halting EXEC and stays high until reset. A pending `out_valid` is still drained in HALT.
- PC wraps: with PC_W = 4, PC 15 + 1 = 0. A BEQ target is computed mod 16.

## Test plan
- Reset:
  - Stimulus: hold `rst` 2 cycles, then release.
  - Required: `imem_addr` = 0 on the first cycle; `out_valid` = 0, `halted` = 0, ALU outputs = 0.
  - Stimulus: assert `rst` during EXEC of ADD r3.
  - Required: no `out_valid`; PC restarts at 0.
- Add overflow:
  - Stimulus: LDI r0,5; LDI r1,5; ADD r3,r0,r1.
  - Required: EXEC drives `alu_a` = 5, `alu_b` = 5, `alu_sel` = 0; `out_data` = 4'b1010 with `out_valid`.
  - Stimulus: LDI r0,4'b1111; LDI r1,4'b1011; ADD r3.
  - Required: `out_data` = 4'b1010.
- NAND:
  - Stimulus: LDI r1,4'b1110; NAND r3,r1,r1.
  - Required: `alu_sel` = 1; `out_data` = 4'b0001.
- Branch:
  - Stimulus: r0 = r1 = 3; BEQ r0,r1,off = 2'b01 at PC = 4.
  - Required: next fetch at PC 6.
  - Stimulus: r1 = 2, same BEQ.
  - Required: next fetch at PC 5.
  - Stimulus: BEQ r0,r0,2'b11.
  - Required: `halted` = 1 and `imem_addr` frozen.
- Backpressure:
  - Stimulus: `out_ready` = 0; LDI r3,7; LDI r3,9.
  - Required: the second instruction stalls in EXEC and `out_data` holds 7.
  - Stimulus: raise `out_ready` for 1 cycle.
  - Required: 7 transfers; `out_data` = 9 next cycle with `out_valid` still 1.
- PC wrap:
  - Stimulus: 16 consecutive LDI instructions.
  - Required: the 17th fetch has `imem_addr` = 0.
